// File: rtl/mover_tablero.sv
// mover_tablero: sequential move engine for the 4x4 2048 board.
// A start latches the board and direction; one line is slid and merged per
// cycle (four cycles in total), then the shifted board, the moved flag and
// the score gained are published together with a one-cycle done pulse.
module mover_tablero (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [2:0] selector,
  input  int         matriz_entrada [4][4],
  output int         matriz_resultante [4][4],
  output logic       ocupado,
  output logic       listo,
  output logic       movido,
  output int         puntos
);

  localparam logic [2:0] DIR_IZQ = 3'b001;
  localparam logic [2:0] DIR_DER = 3'b010;
  localparam logic [2:0] DIR_ARR = 3'b011;
  localparam logic [2:0] DIR_ABA = 3'b100;

  typedef logic [3:0][31:0]       linea_t;
  typedef logic [3:0][3:0][31:0]  tablero_t;

  typedef struct packed {
    linea_t      celdas;
    logic [31:0] pts;
  } deslizado_t;

  typedef enum logic {ESPERA, PROCESA} estado_t;

  estado_t     estado, estado_sig;
  logic [1:0]  idx;
  logic [2:0]  dir;
  logic        dir_valida;
  tablero_t    tablero, tablero_sig, entrada, resultado;
  logic        movido_acc;
  logic [31:0] puntos_acc, puntos_q;
  logic        carga, avanza, ultimo;
  linea_t      linea_in;
  deslizado_t  linea_out;
  logic        cambio_linea;
  logic [1:0]  fila_sel [4];
  logic [1:0]  col_sel  [4];

  // Standard 2048 line rule, element 0 is the leading cell. Nonzero cells
  // are compacted first; c[4] is a permanent zero so the last compacted
  // cell always has a (non-matching) neighbour to compare against.
  function automatic deslizado_t deslizar(input linea_t l);
    logic [4:0][31:0] c;
    logic [2:0]       k;
    logic             saltar;
    deslizado_t       r;
    c = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (l[i] != '0) begin
        c[k] = l[i];
        k    = k + 3'd1;
      end
    end
    r      = '0;
    k      = '0;
    saltar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (saltar) begin
        saltar = 1'b0;
      end else if (c[i] != '0) begin
        if (c[i] == c[i+1]) begin
          r.celdas[k[1:0]] = c[i] << 1;
          r.pts            = r.pts + (c[i] << 1);
          saltar           = 1'b1;
        end else begin
          r.celdas[k[1:0]] = c[i];
        end
        k = k + 3'd1;
      end
    end
    return r;
  endfunction

  // Port-side board conversion between int arrays and the packed datapath.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        entrada[r][c]           = matriz_entrada[r][c];
        matriz_resultante[r][c] = resultado[r][c];
      end
    end
  end

  assign puntos     = puntos_q;
  assign dir_valida = (dir == DIR_IZQ) || (dir == DIR_DER) ||
                      (dir == DIR_ARR) || (dir == DIR_ABA);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= ESPERA;
    else      estado <= estado_sig;
  end

  // Next-state logic: four processing cycles per accepted start.
  always_comb begin
    estado_sig = estado;
    case (estado)
      ESPERA:  if (inicio)       estado_sig = PROCESA;
      PROCESA: if (idx == 2'd3)  estado_sig = ESPERA;
      default:                   estado_sig = ESPERA;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes.
  always_comb begin
    ocupado = (estado == PROCESA);
    carga   = (estado == ESPERA) && inicio;
    avanza  = (estado == PROCESA);
    ultimo  = avanza && (idx == 2'd3);
  end

  // Board coordinates of line idx, leading cell first. Invalid directions
  // reuse the row mapping; their line is passed through untouched anyway.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      case (dir)
        DIR_DER: begin fila_sel[p] = idx;             col_sel[p] = 2'd3 - 2'(p); end
        DIR_ARR: begin fila_sel[p] = 2'(p);           col_sel[p] = idx;          end
        DIR_ABA: begin fila_sel[p] = 2'd3 - 2'(p);    col_sel[p] = idx;          end
        default: begin fila_sel[p] = idx;             col_sel[p] = 2'(p);        end
      endcase
    end
  end

  // Slide/merge the current line and write it back into a board copy.
  always_comb begin
    linea_in = '0;
    for (int p = 0; p < 4; p++) linea_in[p] = tablero[fila_sel[p]][col_sel[p]];
    if (dir_valida) begin
      linea_out = deslizar(linea_in);
    end else begin
      linea_out.celdas = linea_in;
      linea_out.pts    = '0;
    end
    cambio_linea = (linea_out.celdas != linea_in);
    tablero_sig  = tablero;
    for (int p = 0; p < 4; p++) tablero_sig[fila_sel[p]][col_sel[p]] = linea_out.celdas[p];
  end

  // Working board: loaded on start, rewritten one line per processing cycle.
  always_ff @(posedge clk) begin
    if (carga)       tablero <= entrada;
    else if (avanza) tablero <= tablero_sig;
  end

  // Line index, accumulators and published results; outputs change only on
  // the final processing edge so they stay valid until the next move ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      dir        <= '0;
      movido_acc <= 1'b0;
      puntos_acc <= '0;
      resultado  <= '0;
      movido     <= 1'b0;
      puntos_q   <= '0;
      listo      <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (carga) begin
        idx        <= '0;
        dir        <= selector;
        movido_acc <= 1'b0;
        puntos_acc <= '0;
      end else if (avanza) begin
        idx        <= idx + 2'd1;
        movido_acc <= movido_acc | cambio_linea;
        puntos_acc <= puntos_acc + linea_out.pts;
        if (ultimo) begin
          resultado <= tablero_sig;
          movido    <= movido_acc | cambio_linea;
          puntos_q  <= puntos_acc + linea_out.pts;
          listo     <= 1'b1;
        end
      end
    end
  end

endmodule
